// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Bundles the datapath-facing signals of the LEGv8 control sequencer.
//   instr/flags/commandZero : decoded instruction field, stored NZVC flags, ALU zero
//   uncondBr .. read_enable : single-bit datapath controls
//   ALUOp, regRD            : ALU operation and register write address
//   enablePC                : PC advances at the next edge when 1
//   halted, illegal         : halt status (registered), undecoded opcode (combinational)
//   retired                 : saturating count of cycles with enablePC=1
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [11:0]      instr;
  logic [3:0]       flags;
  logic             commandZero;
  logic             uncondBr;
  logic             brTaken;
  logic             BRMI;
  logic             memWrite;
  logic             memToReg;
  logic             ALUSrc;
  logic             regWrite;
  logic             reg2Loc;
  logic             valueToStore;
  logic             dOrImm;
  logic             saveCond;
  logic             read_enable;
  logic [2:0]       ALUOp;
  logic [4:0]       regRD;
  logic             enablePC;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, flags, commandZero,
    output uncondBr, brTaken, BRMI, memWrite, memToReg, ALUSrc, regWrite,
           reg2Loc, valueToStore, dOrImm, saveCond, read_enable, ALUOp, regRD,
           enablePC, halted, illegal, retired
  );

  modport slave (
    output instr, flags, commandZero,
    input  uncondBr, brTaken, BRMI, memWrite, memToReg, ALUSrc, regWrite,
           reg2Loc, valueToStore, dOrImm, saveCond, read_enable, ALUOp, regRD,
           enablePC, halted, illegal, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Multi-cycle control unit for the LEGv8 datapath. Decodes the instruction
// field into datapath controls, stalls the PC for multi-cycle loads, halts on
// the all-zero opcode and counts retired instructions.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : control_sequencer_if master modport (see interface header)
//
// state     | meaning
// EXEC      | decode and execute the current instruction
// LOAD_WAIT | LDUR in flight, waiting for data-memory read latency
// HALT      | all-zero opcode seen; only reset leaves
module control_sequencer #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  control_sequencer_if.master bus
);
  localparam logic [1:0] EXEC      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] HALT      = 2'd2;

  localparam logic [5:0] OP_ADDI  = 6'b100100;
  localparam logic [5:0] OP_ADDS  = 6'b101010;
  localparam logic [5:0] OP_SUBS  = 6'b111010;
  localparam logic [5:0] OP_LDST  = 6'b111110;
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [5:0] OP_CBZ   = 6'b101101;
  localparam logic [5:0] OP_BCOND = 6'b010101;
  localparam logic [5:0] OP_BR    = 6'b110101;
  localparam logic [5:0] OP_HALT  = 6'b000000;

  // Counter is loaded in the issuing EXEC cycle, so LOAD_WAIT spans LOAD_LAT-1 cycles.
  localparam logic [3:0] WAIT_INIT = 4'(LOAD_LAT - 1);

  logic [1:0]       state, state_nx;
  logic [3:0]       wait_cnt, wait_nx;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;

  logic       uncond_br, br_taken, brmi, mem_write, mem_to_reg, alu_src;
  logic       reg_write, reg2loc, value_to_store, d_or_imm, save_cond, read_en;
  logic [2:0] alu_op;
  logic [4:0] reg_rd;
  logic       en_pc, ill;

  logic [5:0] opcode;
  logic       flag_n, flag_z, flag_v;
  logic       cond_met;

  assign opcode = bus.instr[5:0];
  assign flag_n = bus.flags[0];
  assign flag_z = bus.flags[1];
  assign flag_v = bus.flags[2];

  always_comb begin
    cond_met = 1'b0;
    case (bus.instr[10:7])
      4'h0:    cond_met = flag_z;
      4'h1:    cond_met = !flag_z;
      4'hA:    cond_met = (flag_n == flag_v);
      4'hB:    cond_met = (flag_n != flag_v);
      4'hC:    cond_met = !flag_z && (flag_n == flag_v);
      4'hD:    cond_met = flag_z || (flag_n != flag_v);
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    uncond_br = 1'b0; br_taken = 1'b0; brmi = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; alu_src = 1'b0; reg_write = 1'b0; reg2loc = 1'b0;
    value_to_store = 1'b0; d_or_imm = 1'b0; save_cond = 1'b0; read_en = 1'b0;
    alu_op = 3'b000; reg_rd = 5'd0; en_pc = 1'b0; ill = 1'b0;
    state_nx = state;
    wait_nx  = wait_cnt;
    // Outputs stay forced low for the whole time reset is high.
    if (!reset) begin
      case (state)
        EXEC: begin
          en_pc = 1'b1;
          case (opcode)
            OP_ADDI: begin
              alu_op = 3'b010; alu_src = 1'b1; d_or_imm = 1'b1;
              reg_write = 1'b1; reg_rd = bus.instr[11:7];
            end
            OP_ADDS, OP_SUBS: begin
              alu_op = (opcode == OP_SUBS) ? 3'b011 : 3'b010;
              reg2loc = 1'b1; reg_write = 1'b1; save_cond = 1'b1;
              reg_rd = bus.instr[11:7];
            end
            OP_LDST: begin
              alu_op = 3'b010; alu_src = 1'b1;
              if (bus.instr[6]) begin
                mem_to_reg = 1'b1; read_en = 1'b1; reg_rd = bus.instr[11:7];
                if (LOAD_LAT == 1) begin
                  reg_write = 1'b1;
                end else begin
                  en_pc    = 1'b0;
                  state_nx = LOAD_WAIT;
                  wait_nx  = WAIT_INIT;
                end
              end else begin
                mem_write = 1'b1;
              end
            end
            OP_B: begin
              uncond_br = 1'b1; br_taken = 1'b1;
            end
            OP_BL: begin
              uncond_br = 1'b1; br_taken = 1'b1; reg_write = 1'b1;
              value_to_store = 1'b1; reg_rd = 5'd30;
            end
            OP_CBZ:   br_taken = bus.commandZero;
            OP_BCOND: br_taken = cond_met;
            OP_BR: begin
              brmi = 1'b1; br_taken = 1'b1;
            end
            OP_HALT: begin
              en_pc    = 1'b0;
              state_nx = HALT;
            end
            default: ill = 1'b1;
          endcase
        end
        LOAD_WAIT: begin
          alu_op = 3'b010; alu_src = 1'b1; mem_to_reg = 1'b1; read_en = 1'b1;
          reg_rd  = bus.instr[11:7];
          wait_nx = wait_cnt - 4'd1;
          // Data is valid in the final wait cycle: write back and release the PC.
          if (wait_cnt == 4'd1) begin
            reg_write = 1'b1;
            en_pc     = 1'b1;
            state_nx  = EXEC;
          end
        end
        HALT:    state_nx = HALT;
        default: state_nx = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EXEC;
      wait_cnt  <= 4'd0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state_nx == HALT) halted_q <= 1'b1;
      if (en_pc && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.uncondBr     = uncond_br;
  assign bus.brTaken      = br_taken;
  assign bus.BRMI         = brmi;
  assign bus.memWrite     = mem_write;
  assign bus.memToReg     = mem_to_reg;
  assign bus.ALUSrc       = alu_src;
  assign bus.regWrite     = reg_write;
  assign bus.reg2Loc      = reg2loc;
  assign bus.valueToStore = value_to_store;
  assign bus.dOrImm       = d_or_imm;
  assign bus.saveCond     = save_cond;
  assign bus.read_enable  = read_en;
  assign bus.ALUOp        = alu_op;
  assign bus.regRD        = reg_rd;
  assign bus.enablePC     = en_pc;
  assign bus.illegal      = ill;
  assign bus.halted       = halted_q;
  assign bus.retired      = retired_q;
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 32;
  localparam logic [5:0] OPS [9] = '{6'b100100, 6'b101010, 6'b111010, 6'b111110,
                                     6'b000101, 6'b100101, 6'b101101, 6'b010101,
                                     6'b110101};

  typedef struct packed {
    logic       uncondBr, brTaken, BRMI, memWrite, memToReg, ALUSrc, regWrite;
    logic       reg2Loc, valueToStore, dOrImm, saveCond, read_enable;
    logic [2:0] ALUOp;
    logic [4:0] regRD;
    logic       enablePC, illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  longint exp_retired = 0;

  always #5 clk = ~clk;

  control_sequencer_if #(.CNT_W(CNT_W)) bus ();
  control_sequencer #(.LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ctrl_t observed();
    ctrl_t o;
    o.uncondBr = bus.uncondBr; o.brTaken = bus.brTaken; o.BRMI = bus.BRMI;
    o.memWrite = bus.memWrite; o.memToReg = bus.memToReg; o.ALUSrc = bus.ALUSrc;
    o.regWrite = bus.regWrite; o.reg2Loc = bus.reg2Loc;
    o.valueToStore = bus.valueToStore; o.dOrImm = bus.dOrImm;
    o.saveCond = bus.saveCond; o.read_enable = bus.read_enable;
    o.ALUOp = bus.ALUOp; o.regRD = bus.regRD;
    o.enablePC = bus.enablePC; o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v;
    n = f[0]; z = f[1]; v = f[2];
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Expected controls for one EXEC-visible cycle of an instruction; last marks
  // the final cycle of a load.
  function automatic ctrl_t model_ctrl(input logic [11:0] in, input logic [3:0] f,
                                       input logic cz, input bit last);
    ctrl_t c;
    c = '0;
    c.enablePC = 1'b1;
    case (in[5:0])
      6'b100100: begin
        c.ALUOp = 3'b010; c.ALUSrc = 1; c.dOrImm = 1; c.regWrite = 1; c.regRD = in[11:7];
      end
      6'b101010: begin
        c.ALUOp = 3'b010; c.reg2Loc = 1; c.regWrite = 1; c.saveCond = 1; c.regRD = in[11:7];
      end
      6'b111010: begin
        c.ALUOp = 3'b011; c.reg2Loc = 1; c.regWrite = 1; c.saveCond = 1; c.regRD = in[11:7];
      end
      6'b111110: begin
        c.ALUOp = 3'b010; c.ALUSrc = 1;
        if (in[6]) begin
          c.memToReg = 1; c.read_enable = 1; c.regRD = in[11:7];
          c.regWrite = last; c.enablePC = last;
        end else begin
          c.memWrite = 1;
        end
      end
      6'b000101: begin c.uncondBr = 1; c.brTaken = 1; end
      6'b100101: begin
        c.uncondBr = 1; c.brTaken = 1; c.regWrite = 1; c.valueToStore = 1; c.regRD = 5'd30;
      end
      6'b101101: c.brTaken = cz;
      6'b010101: c.brTaken = cond_ok(in[10:7], f);
      6'b110101: begin c.BRMI = 1; c.brTaken = 1; end
      6'b000000: c.enablePC = 1'b0;
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic bit known_op(input logic [5:0] o);
    foreach (OPS[i]) if (OPS[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    ctrl_t got;
    bus.instr = {5'd5, 1'b0, 6'b100100};
    bus.flags = 4'hF;
    bus.commandZero = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== ctrl_t'('0)) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", got, ctrl_t'('0));
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.retired !== '0) begin
      failures++; $display("FAIL reset_state: halted=%b retired=%0d expected 0/0", bus.halted, bus.retired);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_retired = 0;
  endtask

  task automatic test_addi();
    ctrl_t got, e;
    bus.instr = {5'd5, 1'b0, 6'b100100};
    e = '0; e.ALUOp = 3'b010; e.ALUSrc = 1; e.dOrImm = 1; e.regWrite = 1;
    e.regRD = 5'd5; e.enablePC = 1;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== e) begin failures++; $display("FAIL addi_ctrl: got %h expected %h", got, e); end
    @(posedge clk); #1;
    exp_retired++;
    checks++;
    if (bus.retired !== 32'd1) begin
      failures++; $display("FAIL addi_retired: got %0d expected 1", bus.retired);
    end
  endtask

  task automatic test_ldur();
    ctrl_t got, e;
    longint start;
    start = exp_retired;
    bus.instr = {5'd3, 1'b1, 6'b111110};
    for (int k = 0; k < LOAD_LAT; k++) begin
      e = '0; e.ALUOp = 3'b010; e.ALUSrc = 1; e.memToReg = 1; e.read_enable = 1;
      e.regRD = 5'd3; e.regWrite = (k == LOAD_LAT - 1); e.enablePC = (k == LOAD_LAT - 1);
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== e) begin failures++; $display("FAIL ldur_cycle%0d: got %h expected %h", k, got, e); end
      @(posedge clk); #1;
    end
    exp_retired = start + 1;
    checks++;
    if (bus.retired !== exp_retired[CNT_W-1:0]) begin
      failures++; $display("FAIL ldur_retired: got %0d expected %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_subs_bcond();
    ctrl_t got, e;
    logic [3:0] fl [2] = '{4'b0001, 4'b0101};
    for (int i = 0; i < 2; i++) begin
      bus.flags = fl[i];
      bus.instr = {5'd9, 1'b0, 6'b111010};
      e = '0; e.ALUOp = 3'b011; e.reg2Loc = 1; e.regWrite = 1; e.saveCond = 1;
      e.regRD = 5'd9; e.enablePC = 1;
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== e) begin failures++; $display("FAIL subs_ctrl: got %h expected %h", got, e); end
      @(posedge clk); #1; exp_retired++;
      bus.instr = {1'b0, 4'hB, 1'b0, 6'b010101};
      @(negedge clk);
      checks++;
      if (bus.brTaken !== (i == 0) || bus.enablePC !== 1'b1) begin
        failures++;
        $display("FAIL bcond_lt_%0d: brTaken=%b enablePC=%b expected %b/1", i, bus.brTaken, bus.enablePC, (i == 0));
      end
      @(posedge clk); #1; exp_retired++;
    end
  endtask

  task automatic test_cbz();
    for (int i = 0; i < 2; i++) begin
      bus.instr = {5'd2, 1'b0, 6'b101101};
      bus.commandZero = (i == 0);
      @(negedge clk);
      checks++;
      if (bus.brTaken !== (i == 0) || bus.uncondBr !== 1'b0 || bus.regWrite !== 1'b0) begin
        failures++;
        $display("FAIL cbz_%0d: brTaken=%b uncondBr=%b regWrite=%b expected %b/0/0",
                 i, bus.brTaken, bus.uncondBr, bus.regWrite, (i == 0));
      end
      @(posedge clk); #1; exp_retired++;
    end
  endtask

  task automatic test_bl_illegal();
    ctrl_t got, e;
    bus.instr = {5'd4, 1'b0, 6'b100101};
    e = '0; e.uncondBr = 1; e.brTaken = 1; e.regWrite = 1; e.valueToStore = 1;
    e.regRD = 5'd30; e.enablePC = 1;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== e) begin failures++; $display("FAIL bl_ctrl: got %h expected %h", got, e); end
    @(posedge clk); #1; exp_retired++;
    bus.instr = {5'd4, 1'b0, 6'b111111};
    e = '0; e.enablePC = 1; e.illegal = 1;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== e) begin failures++; $display("FAIL illegal_ctrl: got %h expected %h", got, e); end
    @(posedge clk); #1; exp_retired++;
    checks++;
    if (bus.retired !== exp_retired[CNT_W-1:0]) begin
      failures++; $display("FAIL bl_illegal_retired: got %0d expected %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_random();
    ctrl_t got, e;
    logic [5:0] op;
    int cycles;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(1, 63)); while (known_op(op));
      end else begin
        op = OPS[$urandom_range(0, 8)];
      end
      bus.instr = {5'($urandom), 1'($urandom), op};
      bus.flags = 4'($urandom);
      bus.commandZero = 1'($urandom);
      cycles = (op == 6'b111110 && bus.instr[6]) ? LOAD_LAT : 1;
      for (int k = 0; k < cycles; k++) begin
        e = model_ctrl(bus.instr, bus.flags, bus.commandZero, (k == cycles - 1));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== e) begin
          failures++; $display("FAIL random_ctrl instr=%h k=%0d: got %h expected %h", bus.instr, k, got, e);
        end
        @(posedge clk); #1;
        if (e.enablePC) exp_retired++;
      end
      checks++;
      if (bus.retired !== exp_retired[CNT_W-1:0] || bus.halted !== 1'b0) begin
        failures++;
        $display("FAIL random_retired: got %0d halted=%b expected %0d halted=0", bus.retired, bus.halted, exp_retired);
      end
    end
  endtask

  task automatic test_reset_in_load();
    ctrl_t got, e;
    bus.instr = {5'd7, 1'b1, 6'b111110};
    @(posedge clk); #1;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== ctrl_t'('0) || bus.retired !== '0 || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_load: got %h retired=%0d halted=%b expected 0", got, bus.retired, bus.halted);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_retired = 0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      e = '0; e.ALUOp = 3'b010; e.ALUSrc = 1; e.memToReg = 1; e.read_enable = 1;
      e.regRD = 5'd7; e.regWrite = (k == LOAD_LAT - 1); e.enablePC = (k == LOAD_LAT - 1);
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== e) begin failures++; $display("FAIL reload_cycle%0d: got %h expected %h", k, got, e); end
      @(posedge clk); #1;
    end
    exp_retired = 1;
    checks++;
    if (bus.retired !== 32'd1) begin
      failures++; $display("FAIL reload_retired: got %0d expected 1", bus.retired);
    end
  endtask

  task automatic test_halt();
    ctrl_t got, e;
    bus.instr = 12'h000;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== ctrl_t'('0)) begin failures++; $display("FAIL halt_exec: got %h expected 0", got); end
    @(posedge clk); #1;
    checks++;
    if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", bus.halted); end
    for (int k = 0; k < 5; k++) begin
      bus.instr = {5'($urandom), 1'b0, 6'b100100};
      @(negedge clk);
      got = observed();
      checks++;
      if (got !== ctrl_t'('0) || bus.halted !== 1'b1) begin
        failures++; $display("FAIL halt_hold%0d: got %h halted=%b expected 0/1", k, got, bus.halted);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.retired !== exp_retired[CNT_W-1:0]) begin
      failures++; $display("FAIL halt_retired: got %0d expected %0d", bus.retired, exp_retired);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_exit: halted=%b expected 0", bus.halted); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_retired = 0;
    bus.instr = {5'd12, 1'b0, 6'b100100};
    e = '0; e.ALUOp = 3'b010; e.ALUSrc = 1; e.dOrImm = 1; e.regWrite = 1;
    e.regRD = 5'd12; e.enablePC = 1;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== e) begin failures++; $display("FAIL post_halt_addi: got %h expected %h", got, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.instr = 12'h000;
    bus.flags = 4'h0;
    bus.commandZero = 1'b0;
    test_reset();
    test_addi();
    test_ldur();
    test_subs_bcond();
    test_cbz();
    test_bl_illegal();
    test_random();
    test_reset_in_load();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
